voice_allocator: RTL and testbench
==================================

# voice_allocator

Event-driven scheduler that shares a bank of N oscillator voices between incoming note-on/note-off events. It decides which voice plays each note, drives each voice's enable, frequency and envelope-reset command, and runs a per-voice release hold before freeing the voice. It sits between the command/protocol decoder and the oscillator array, so the oscillators only ever see configuration from this block.

## Interface
- N_VOICES, 8, number of oscillator voices managed (≥2)
- FREQ_W, 32, frequency word width (fixed point, `FREQ_FIXED_POINT` fraction bits)
- AGE_W, 16, width of per-voice saturating age counter
- REL_W, 24, width of release-hold counter

- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept an event
- ev_note_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  7  note number
- ev_freq  in  FREQ_W  oscillator frequency for note-on; ignored for note-off
- release_len  in  REL_W  release hold in cycles, sampled at note-off commit
- voice_enable  out  N_VOICES  per-voice oscillator enable
- voice_freq  out  N_VOICES×FREQ_W  per-voice frequency
- voice_cmds  out  N_VOICES×8  per-voice command byte; only `ENVELOPE_RESET_BIT` is ever set
- active_count  out  $clog2(N_VOICES)+1  number of voices not FREE

## Operation
- Voice state per slot: FREE, ACTIVE, RELEASING. Each slot has key, freq, age, release counter.
- Controller FSM: IDLE → SCAN → COMMIT → IDLE.
  - IDLE: ev_ready=1. Handshake on ev_valid&ev_ready latches note_on/key/freq; go to SCAN with idx=0.
  - SCAN: examine slot idx per cycle, idx 0..N_VOICES-1, tracking: first slot with matching key (state≠FREE), first FREE slot (lowest index), and oldest slot (max age; tie → lowest index). After idx=N_VOICES-1 go to COMMIT.
  - COMMIT, note-on: target = key match, else first FREE, else oldest (steal). Target gets state ACTIVE, key, freq; age=0; the ENVELOPE_RESET bit in voice_cmds[target] is pulsed for exactly one cycle.
  - COMMIT, note-off: if key match in ACTIVE, that slot goes RELEASING with counter=release_len. If there is no match, or the match is already RELEASING, the event is consumed with no effect.
- Background, every cycle, all slots:
  - age increments, saturating at 2^AGE_W−1, while state≠FREE.
  - RELEASING counter decrements. When the counter is 0 in a cycle, the slot becomes FREE the next cycle. So release_len=0 frees the slot one cycle after commit.
- voice_enable[i] = (state≠FREE). voice_freq holds its last value when FREE.
- Simultaneous events: a COMMIT to a slot overrides that slot's background release/free in the same cycle. SCAN reads live slot state, so a slot freed after its index was scanned is not reconsidered for the current event.

## Timing
- Reset values: ev_ready=0 during reset and 1 in the first cycle after rstn deasserts. All slots FREE, voice_enable=0, voice_freq=0, voice_cmds=0, ages=0, active_count=0.
- Latency: from the acceptance edge, ev_ready is low for N_VOICES+1 cycles. Slot outputs update on the edge ending COMMIT, i.e. N_VOICES+1 cycles after acceptance. The next event can be accepted in the following cycle.
- All outputs are registered; there is no combinational path from ev_* to outputs except none (ev_ready depends only on FSM state).
- rstn low mid-SCAN/COMMIT aborts the event; no slot is modified by it.

## Structure
- Shared package (protocol_pkg): voice_state_t enum {FREE, ACTIVE, RELEASING}, and the event struct (note_on, key, freq). `ENVELOPE_RESET_BIT` and `FREQ_FIXED_POINT` stay in constants.svh.
- Sub-module voice_slot, instantiated N_VOICES times. It holds state, key, freq, age, release counter and the cmd pulse. It takes load_on/load_off strobes from the controller, and its outputs are used for enable, freq, cmds and scan compare.
- Top level holds the FSM, scan index, best-candidate registers and the popcount for active_count.

## Test plan
- After reset, note-on key 60, freq 0x6E000 → slot 0 enabled, freq 0x6E000, cmds[0] reset bit high exactly one cycle, active_count=1, ev_ready low 9 cycles (N=8).
- Eight note-ons with distinct keys, then a ninth (key 72) → slot 0 (oldest) stolen: key 72, new freq, reset pulse; active_count stays 8.
- Note-on key 60 twice → second retriggers the same slot (reset pulse, age 0) with no new slot used.
- Note-off key 60 with release_len=5 → enable stays high, slot goes FREE and enable drops on the 6th cycle after COMMIT. Note-off key 99 (unmatched) → accepted, no output change.
- A note-on arrives while the last free slot is RELEASING with counter at 0 → the COMMIT targets the freed slot or steals deterministically as specified; rstn pulsed mid-SCAN → all outputs return to reset values and the pending event is lost.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator: slot state encoding,
// controller states, the latched event record and command-byte layout.
package voice_allocator_pkg;

    // Bit of the per-voice command byte that restarts the oscillator envelope.
    localparam int unsigned ENVELOPE_RESET_BIT = 0;
    // Number of fraction bits in the oscillator frequency word.
    localparam int unsigned FREQ_FIXED_POINT   = 16;
    // Frequency word width carried by the event record.
    localparam int unsigned EV_FREQ_W          = 32;
    // Note number width.
    localparam int unsigned KEY_W              = 7;

    typedef enum logic [1:0] {
        VS_FREE      = 2'd0,
        VS_ACTIVE    = 2'd1,
        VS_RELEASING = 2'd2
    } voice_state_t;

    typedef enum logic [1:0] {
        CT_IDLE   = 2'd0,
        CT_SCAN   = 2'd1,
        CT_COMMIT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic                 note_on;
        logic [KEY_W-1:0]     key;
        logic [EV_FREQ_W-1:0] freq;
    } voice_event_t;

endpackage

// File: rtl/voice_allocator_slot.sv
// One oscillator voice: holds state, key, frequency, saturating age and the
// release-hold counter, and pulses the envelope-reset command on a load.
module voice_allocator_slot
    import voice_allocator_pkg::*;
#(
    parameter int unsigned FREQ_W = EV_FREQ_W,
    parameter int unsigned AGE_W  = 16,
    parameter int unsigned REL_W  = 24
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load_on_i,
    input  logic               load_off_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [FREQ_W-1:0]  freq_i,
    input  logic [REL_W-1:0]   rel_len_i,
    output voice_state_t       state_o,
    output logic [KEY_W-1:0]   key_o,
    output logic [AGE_W-1:0]   age_o,
    output logic [FREQ_W-1:0]  freq_o,
    output logic [7:0]         cmd_o,
    output logic               enable_o,
    output logic               enable_next_o
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    voice_state_t        state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [AGE_W-1:0]    age_q, age_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic [7:0]          cmd_q, cmd_d;

    // Slot register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= VS_FREE;
            key_q   <= '0;
            freq_q  <= '0;
            age_q   <= '0;
            rel_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            freq_q  <= freq_d;
            age_q   <= age_d;
            rel_q   <= rel_d;
            cmd_q   <= cmd_d;
        end
    end

    // Background aging/release, overridden by controller load strobes.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        freq_d  = freq_q;
        age_d   = age_q;
        rel_d   = rel_q;
        cmd_d   = '0;

        if (state_q != VS_FREE && age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
        end

        if (state_q == VS_RELEASING) begin
            if (rel_q == '0) begin
                state_d = VS_FREE;
            end else begin
                rel_d = rel_q - REL_W'(1);
            end
        end

        // A commit to this slot wins over its own release/free this cycle.
        if (load_on_i) begin
            state_d                   = VS_ACTIVE;
            key_d                     = key_i;
            freq_d                    = freq_i;
            age_d                     = '0;
            rel_d                     = '0;
            cmd_d[ENVELOPE_RESET_BIT] = 1'b1;
        end else if (load_off_i) begin
            state_d = VS_RELEASING;
            rel_d   = rel_len_i;
        end
    end

    assign state_o       = state_q;
    assign key_o         = key_q;
    assign age_o         = age_q;
    assign freq_o        = freq_q;
    assign cmd_o         = cmd_q;
    assign enable_o      = (state_q != VS_FREE);
    assign enable_next_o = (state_d != VS_FREE);

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator top: accepts note events, scans the slot bank one slot per
// cycle for key match / free / oldest candidates, then commits the event.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int unsigned N_VOICES = 8,
    parameter int unsigned FREQ_W   = EV_FREQ_W,
    parameter int unsigned AGE_W    = 16,
    parameter int unsigned REL_W    = 24
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_note_on,
    input  logic [KEY_W-1:0]              ev_key,
    input  logic [FREQ_W-1:0]             ev_freq,
    input  logic [REL_W-1:0]              release_len,
    output logic [N_VOICES-1:0]           voice_enable,
    output logic [N_VOICES*FREQ_W-1:0]    voice_freq,
    output logic [N_VOICES*8-1:0]         voice_cmds,
    output logic [$clog2(N_VOICES):0]     active_count
);

    localparam int unsigned IDX_W = $clog2(N_VOICES);
    localparam int unsigned CNT_W = $clog2(N_VOICES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    ctrl_state_t         st_q, st_d;
    logic                ready_q, ready_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    voice_event_t        ev_q, ev_d;
    logic                match_vld_q, match_vld_d;
    logic                match_act_q, match_act_d;
    logic [IDX_W-1:0]    match_idx_q, match_idx_d;
    logic                free_vld_q, free_vld_d;
    logic [IDX_W-1:0]    free_idx_q, free_idx_d;
    logic [IDX_W-1:0]    old_idx_q, old_idx_d;
    logic [AGE_W-1:0]    old_age_q, old_age_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    voice_state_t        slot_state [N_VOICES];
    logic [KEY_W-1:0]    slot_key   [N_VOICES];
    logic [AGE_W-1:0]    slot_age   [N_VOICES];
    logic [N_VOICES-1:0] load_on, load_off, enable_nx;
    logic [IDX_W-1:0]    tgt;

    voice_state_t        cur_state;
    logic [KEY_W-1:0]    cur_key;
    logic [AGE_W-1:0]    cur_age;

    for (genvar g = 0; g < N_VOICES; g++) begin : g_slot
        voice_allocator_slot #(
            .FREQ_W (FREQ_W),
            .AGE_W  (AGE_W),
            .REL_W  (REL_W)
        ) u_slot (
            .clk           (clk),
            .rstn          (rstn),
            .load_on_i     (load_on[g]),
            .load_off_i    (load_off[g]),
            .key_i         (ev_q.key),
            .freq_i        (ev_q.freq),
            .rel_len_i     (release_len),
            .state_o       (slot_state[g]),
            .key_o         (slot_key[g]),
            .age_o         (slot_age[g]),
            .freq_o        (voice_freq[g*FREQ_W +: FREQ_W]),
            .cmd_o         (voice_cmds[g*8 +: 8]),
            .enable_o      (voice_enable[g]),
            .enable_next_o (enable_nx[g])
        );
    end

    assign cur_state = slot_state[idx_q];
    assign cur_key   = slot_key[idx_q];
    assign cur_age   = slot_age[idx_q];

    // Controller and candidate registers; reset aborts any event in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q        <= CT_IDLE;
            ready_q     <= 1'b0;
            idx_q       <= '0;
            ev_q        <= '0;
            match_vld_q <= 1'b0;
            match_act_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            cnt_q       <= '0;
        end else begin
            st_q        <= st_d;
            ready_q     <= ready_d;
            idx_q       <= idx_d;
            ev_q        <= ev_d;
            match_vld_q <= match_vld_d;
            match_act_q <= match_act_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: accept, scan one slot per cycle, commit to target.
    always_comb begin
        st_d        = st_q;
        idx_d       = idx_q;
        ev_d        = ev_q;
        match_vld_d = match_vld_q;
        match_act_d = match_act_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        load_on     = '0;
        load_off    = '0;
        tgt         = '0;

        case (st_q)
            CT_IDLE: begin
                if (ev_valid && ready_q) begin
                    ev_d.note_on = ev_note_on;
                    ev_d.key     = ev_key;
                    ev_d.freq    = ev_freq;
                    st_d         = CT_SCAN;
                    idx_d        = '0;
                    match_vld_d  = 1'b0;
                    match_act_d  = 1'b0;
                    free_vld_d   = 1'b0;
                    old_idx_d    = '0;
                    old_age_d    = '0;
                end
            end
            CT_SCAN: begin
                if (!match_vld_q && cur_state != VS_FREE && cur_key == ev_q.key) begin
                    match_vld_d = 1'b1;
                    match_act_d = (cur_state == VS_ACTIVE);
                    match_idx_d = idx_q;
                end
                if (!free_vld_q && cur_state == VS_FREE) begin
                    free_vld_d = 1'b1;
                    free_idx_d = idx_q;
                end
                if (idx_q == '0 || cur_age > old_age_q) begin
                    old_idx_d = idx_q;
                    old_age_d = cur_age;
                end
                if (idx_q == LAST_IDX) begin
                    st_d = CT_COMMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            CT_COMMIT: begin
                st_d = CT_IDLE;
                if (ev_q.note_on) begin
                    if (match_vld_q) begin
                        tgt = match_idx_q;
                    end else if (free_vld_q) begin
                        tgt = free_idx_q;
                    end else begin
                        tgt = old_idx_q;
                    end
                    load_on[tgt] = 1'b1;
                end else if (match_vld_q && match_act_q) begin
                    load_off[match_idx_q] = 1'b1;
                end
            end
            default: begin
                st_d = CT_IDLE;
            end
        endcase
    end

    // ev_ready is registered from the next controller state so it is low in reset.
    always_comb begin
        ready_d = (st_d == CT_IDLE);
    end

    // Popcount of next-cycle enables keeps active_count aligned with voice_enable.
    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < N_VOICES; i++) begin
            cnt_d = cnt_d + CNT_W'(enable_nx[i]);
        end
    end

    assign ev_ready     = ready_q;
    assign active_count = cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against a slot-level reference model.
module tb_voice_allocator;

    localparam int N  = 8;
    localparam int FW = 32;
    localparam int AW = 16;
    localparam int RW = 24;

    logic                clk = 1'b0;
    logic                rstn;
    logic                ev_valid;
    logic                ev_ready;
    logic                ev_note_on;
    logic [6:0]          ev_key;
    logic [FW-1:0]       ev_freq;
    logic [RW-1:0]       release_len;
    logic [N-1:0]        voice_enable;
    logic [N*FW-1:0]     voice_freq;
    logic [N*8-1:0]      voice_cmds;
    logic [3:0]          active_count;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = free, 1 = active, 2 = releasing.
    int          m_state [N];
    logic [6:0]  m_key   [N];
    logic [31:0] m_freq  [N];
    int unsigned m_age   [N];
    int unsigned m_rel   [N];
    bit          m_cmd   [N];

    voice_allocator #(
        .N_VOICES (N),
        .FREQ_W   (FW),
        .AGE_W    (AW),
        .REL_W    (RW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_note_on   (ev_note_on),
        .ev_key       (ev_key),
        .ev_freq      (ev_freq),
        .release_len  (release_len),
        .voice_enable (voice_enable),
        .voice_freq   (voice_freq),
        .voice_cmds   (voice_cmds),
        .active_count (active_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_key[i]   = '0;
            m_freq[i]  = '0;
            m_age[i]   = 0;
            m_rel[i]   = 0;
            m_cmd[i]   = 1'b0;
        end
    endfunction

    // What every slot does on its own across one clock edge.
    function automatic void model_bg();
        for (int i = 0; i < N; i++) begin
            m_cmd[i] = 1'b0;
            if (m_state[i] != 0 && m_age[i] < 65535) m_age[i]++;
            if (m_state[i] == 2) begin
                if (m_rel[i] == 0) m_state[i] = 0;
                else m_rel[i]--;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        int cnt;
        logic [FW-1:0] f;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            f = voice_freq[i*FW +: FW];
            chk($sformatf("%s_en%0d", tag, i), 64'(voice_enable[i]), 64'(m_state[i] != 0));
            chk($sformatf("%s_fq%0d", tag, i), 64'(f), 64'(m_freq[i]));
            chk($sformatf("%s_cmd%0d", tag, i), 64'(voice_cmds[i*8 +: 8]), 64'(m_cmd[i] ? 8'h01 : 8'h00));
            if (m_state[i] != 0) cnt++;
        end
        chk($sformatf("%s_cnt", tag), 64'(active_count), 64'(cnt));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            model_bg();
            tick();
            check_all("idle");
        end
    endtask

    task automatic do_reset(input int n);
        rstn     = 1'b0;
        ev_valid = 1'b0;
        for (int c = 0; c < n; c++) tick();
        model_clear();
        chk("rst_rdy", 64'(ev_ready), 64'd0);
        check_all("rst");
        rstn = 1'b1;
        model_bg();
        tick();
        chk("rst_rdy1", 64'(ev_ready), 64'd1);
        check_all("postrst");
    endtask

    // One full event: accept, N scan cycles, commit; model applies the rules.
    task automatic send_event(input bit on, input logic [6:0] key, input logic [31:0] freq,
                              input logic [RW-1:0] rel);
        bit mv, fv, mact;
        int mi, fi, oi, tgt;
        int unsigned oage;
        chk("rdy_acc", 64'(ev_ready), 64'd1);
        ev_valid    = 1'b1;
        ev_note_on  = on;
        ev_key      = key;
        ev_freq     = freq;
        release_len = rel;
        model_bg();
        tick();
        ev_valid   = 1'b0;
        ev_note_on = 1'($urandom);
        ev_key     = 7'($urandom);
        ev_freq    = $urandom;
        mv = 0; fv = 0; mact = 0; mi = 0; fi = 0; oi = 0; oage = 0;
        for (int k = 0; k < N; k++) begin
            chk("rdy_scan", 64'(ev_ready), 64'd0);
            if (!mv && m_state[k] != 0 && m_key[k] == key) begin
                mv = 1; mi = k; mact = (m_state[k] == 1);
            end
            if (!fv && m_state[k] == 0) begin
                fv = 1; fi = k;
            end
            if (k == 0 || m_age[k] > oage) begin
                oi = k; oage = m_age[k];
            end
            model_bg();
            tick();
            check_all("scan");
        end
        chk("rdy_commit", 64'(ev_ready), 64'd0);
        model_bg();
        if (on) begin
            tgt = mv ? mi : (fv ? fi : oi);
            m_state[tgt] = 1;
            m_key[tgt]   = key;
            m_freq[tgt]  = freq;
            m_age[tgt]   = 0;
            m_rel[tgt]   = 0;
            m_cmd[tgt]   = 1'b1;
        end else if (mv && mact) begin
            m_state[mi] = 2;
            m_rel[mi]   = rel;
        end
        tick();
        check_all("commit");
        chk("rdy_after", 64'(ev_ready), 64'd1);
    endtask

    initial begin
        rstn        = 1'b0;
        ev_valid    = 1'b0;
        ev_note_on  = 1'b0;
        ev_key      = '0;
        ev_freq     = '0;
        release_len = '0;
        model_clear();

        do_reset(3);

        // First note lands in slot 0 with a one-cycle envelope reset.
        send_event(1'b1, 7'd60, 32'h0006_E000, '0);
        chk("first_en0", 64'(voice_enable), 64'h01);
        chk("first_cmd0", 64'(voice_cmds[7:0]), 64'h01);
        idle(1);
        chk("first_cmd0_clr", 64'(voice_cmds[7:0]), 64'h00);

        // Retrigger of the same key reuses its slot.
        send_event(1'b1, 7'd60, 32'h0007_0000, '0);
        chk("retrig_cnt", 64'(active_count), 64'd1);
        idle(2);

        // Note-off with release hold of 5, then an unmatched note-off.
        send_event(1'b0, 7'd60, '0, 24'd5);
        idle(5);
        chk("rel_hold_en", 64'(voice_enable[0]), 64'd1);
        idle(1);
        chk("rel_free_en", 64'(voice_enable[0]), 64'd0);
        send_event(1'b0, 7'd99, '0, 24'd3);
        idle(2);

        // Fill all voices, then steal the oldest.
        for (int k = 0; k < N; k++) send_event(1'b1, 7'(40 + k), 32'h1000 + 32'(k), '0);
        send_event(1'b1, 7'd72, 32'h0009_9000, '0);
        chk("steal_cnt", 64'(active_count), 64'd8);
        chk("steal_fq0", 64'(voice_freq[FW-1:0]), 64'h0009_9000);

        // Slot releases so it reaches zero while its index is scanned.
        send_event(1'b0, 7'd45, '0, 24'd6);
        send_event(1'b1, 7'd91, 32'h0000_5151, '0);
        // Slot frees just before its index is scanned.
        send_event(1'b0, 7'd46, '0, 24'd6);
        send_event(1'b1, 7'd92, 32'h0000_5252, '0);
        // Release length 0.
        send_event(1'b0, 7'd47, '0, 24'd0);
        send_event(1'b1, 7'd93, 32'h0000_5353, '0);
        idle(3);

        // Reset in the middle of a scan drops the pending event.
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_key     = 7'd11;
        ev_freq    = 32'hDEAD;
        model_bg();
        tick();
        ev_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            model_bg();
            tick();
        end
        do_reset(2);
        idle(N + 3);

        // Randomized traffic.
        for (int e = 0; e < 60; e++) begin
            idle($urandom_range(0, 3));
            send_event(($urandom_range(0, 9) < 6), 7'(60 + $urandom_range(0, 9)),
                       $urandom, RW'($urandom_range(0, 15)));
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
